// File: rtl/peripheral_wb_ram_model.sv
// Wishbone B4 registered-feedback slave RAM with LFSR-randomised read latency,
// fixed write latency, CTI/BTE bursts, out-of-range error beats and beat counters.
module peripheral_wb_ram_model #(
    parameter int unsigned DW             = 32,
    parameter int unsigned AW             = 32,
    parameter int unsigned MEM_SIZE_BYTES = 32'h0000_8000,
    parameter int unsigned RD_MIN_DELAY   = 0,
    parameter int unsigned RD_MAX_DELAY   = 4,
    parameter int unsigned WR_DELAY       = 0,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [AW-1:0]   wb_adr_i,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic            wb_we_i,
    input  logic [1:0]      wb_bte_i,
    input  logic [2:0]      wb_cti_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    output logic            wb_ack_o,
    output logic            wb_err_o,
    output logic            wb_rty_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [31:0]     rd_count_o,
    output logic [31:0]     wr_count_o,
    output logic            busy_o
);
    localparam int unsigned BYTES     = DW / 8;
    localparam int unsigned BW        = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int unsigned MEM_WORDS = MEM_SIZE_BYTES / BYTES;
    localparam int unsigned MW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned RD_RANGE  = RD_MAX_DELAY - RD_MIN_DELAY + 1;
    localparam logic [AW-1:0] MEM_LIMIT = AW'(MEM_WORDS * BYTES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [DW-1:0] mem [MEM_WORDS];

    state_t          state_q;
    logic [AW-1:0]   beat_adr_q;
    logic [15:0]     wcnt_q;
    logic            we_q;
    logic            ack_q;
    logic            err_q;
    logic [DW-1:0]   dat_q;
    logic [31:0]     rd_cnt_q;
    logic [31:0]     wr_cnt_q;
    logic [15:0]     lfsr_q;

    logic [15:0]     lfsr_d;
    logic [15:0]     wcnt_d;
    logic [AW-1:0]   beat_adr_d;
    logic [AW-1:0]   wrap_mask;
    logic [MW-1:0]   word_idx;
    logic            in_range;
    logic [DW-1:0]   rdata;
    logic            burst_go;

    // Galois LFSR, taps 16,14,13,11
    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    assign wcnt_d = wb_we_i ? 16'(WR_DELAY)
                            : 16'(RD_MIN_DELAY) + (lfsr_q % 16'(RD_RANGE));

    assign word_idx = beat_adr_q[BW +: MW];
    assign in_range = beat_adr_q < MEM_LIMIT;
    assign burst_go = wb_cyc_i && wb_stb_i && (wb_cti_i == 3'b010);

    // Wrap bursts only advance the low bits covering the wrap window.
    always_comb begin
        wrap_mask = '1;
        case (wb_bte_i)
            2'b01:   wrap_mask = AW'(4 * BYTES - 1);
            2'b10:   wrap_mask = AW'(8 * BYTES - 1);
            2'b11:   wrap_mask = AW'(16 * BYTES - 1);
            default: wrap_mask = '1;
        endcase
        beat_adr_d = (beat_adr_q & ~wrap_mask) | ((beat_adr_q + AW'(BYTES)) & wrap_mask);
    end

    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (wb_sel_i[i]) rdata[8*i +: 8] = mem[word_idx][8*i +: 8];
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            beat_adr_q <= '0;
            wcnt_q     <= '0;
            we_q       <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            lfsr_q     <= LFSR_SEED;
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    if (wb_cyc_i && wb_stb_i) begin
                        beat_adr_q <= wb_adr_i;
                        we_q       <= wb_we_i;
                        wcnt_q     <= wcnt_d;
                        lfsr_q     <= lfsr_d;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (!wb_cyc_i) begin
                        state_q <= IDLE;
                    end else if (wcnt_q == '0) begin
                        state_q <= RESP;
                        if (in_range) begin
                            ack_q <= 1'b1;
                            if (we_q) begin
                                wr_cnt_q <= wr_cnt_q + 32'd1;
                            end else begin
                                dat_q    <= rdata;
                                rd_cnt_q <= rd_cnt_q + 32'd1;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        wcnt_q <= wcnt_q - 16'd1;
                    end
                end
                RESP: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    // Master still holds the acked beat's cti here, so it decides continuation.
                    if (burst_go) begin
                        beat_adr_q <= beat_adr_d;
                        we_q       <= wb_we_i;
                        wcnt_q     <= wcnt_d;
                        lfsr_q     <= lfsr_d;
                        state_q    <= WAIT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Write data is taken during the ack cycle, while the master still drives the beat.
    always_ff @(posedge wb_clk_i) begin
        if (state_q == RESP && ack_q && we_q && wb_cyc_i) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (wb_sel_i[i]) mem[word_idx][8*i +: 8] <= wb_dat_i[8*i +: 8];
            end
        end
    end

    assign wb_ack_o   = ack_q & wb_cyc_i;
    assign wb_err_o   = err_q & wb_cyc_i;
    assign wb_rty_o   = 1'b0;
    assign wb_dat_o   = dat_q;
    assign rd_count_o = rd_cnt_q;
    assign wr_count_o = wr_cnt_q;
    assign busy_o     = (state_q != IDLE);
endmodule

// File: tb/tb_peripheral_wb_ram_model.sv
// Bench for peripheral_wb_ram_model: default-latency instance A and a fixed
// 2-cycle read latency instance B share one bus; cyc selects the target.
module tb_peripheral_wb_ram_model;
    logic        clk;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic [1:0]  bte;
    logic [2:0]  cti;
    logic        cyc;
    logic        stb;
    logic        tgt;

    logic        ack_a, err_a, rty_a, busy_a;
    logic        ack_b, err_b, rty_b, busy_b;
    logic [31:0] dat_a, rdc_a, wrc_a;
    logic [31:0] dat_b, rdc_b, wrc_b;

    logic        ack_m, err_m, busy_m;
    logic [31:0] dat_m, rdc_m, wrc_m;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_dat_q[$];
    int          exp_lat_q[$];

    peripheral_wb_ram_model dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat),
        .wb_sel_i(sel), .wb_we_i(we), .wb_bte_i(bte), .wb_cti_i(cti),
        .wb_cyc_i(cyc & ~tgt), .wb_stb_i(stb), .wb_ack_o(ack_a), .wb_err_o(err_a),
        .wb_rty_o(rty_a), .wb_dat_o(dat_a), .rd_count_o(rdc_a), .wr_count_o(wrc_a),
        .busy_o(busy_a)
    );

    peripheral_wb_ram_model #(.RD_MIN_DELAY(2), .RD_MAX_DELAY(2)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat),
        .wb_sel_i(sel), .wb_we_i(we), .wb_bte_i(bte), .wb_cti_i(cti),
        .wb_cyc_i(cyc & tgt), .wb_stb_i(stb), .wb_ack_o(ack_b), .wb_err_o(err_b),
        .wb_rty_o(rty_b), .wb_dat_o(dat_b), .rd_count_o(rdc_b), .wr_count_o(wrc_b),
        .busy_o(busy_b)
    );

    assign ack_m  = tgt ? ack_b  : ack_a;
    assign err_m  = tgt ? err_b  : err_a;
    assign busy_m = tgt ? busy_b : busy_a;
    assign dat_m  = tgt ? dat_b  : dat_a;
    assign rdc_m  = tgt ? rdc_b  : rdc_a;
    assign wrc_m  = tgt ? wrc_b  : wrc_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    task automatic do_reset();
        cyc = 0; stb = 0; we = 0; cti = 0; bte = 0; tgt = 0;
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
    endtask

    // One classic beat; lat counts rising edges from stb sampling to visible ack/err, -1 on timeout.
    task automatic classic_xfer(input bit t, input bit w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, output logic [31:0] rd, output int lat,
                                output bit e, output bit post);
        tgt = t; we = w; adr = a; dat = d; sel = s; cti = 3'b000; bte = 2'b00;
        cyc = 1; stb = 1; lat = 0; rd = '0; e = 0; post = 0;
        forever begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (ack_m || err_m) break;
            if (lat >= 40) begin lat = -1; break; end
        end
        rd = dat_m; e = err_m;
        @(posedge clk);
        @(negedge clk);
        post = ack_m | err_m;
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack_a); end
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        n_checks++; if (dat_a !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %h want 0", dat_a); end
        n_checks++; if (rdc_a !== 32'h0 || wrc_a !== 32'h0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0", rdc_a, wrc_a); end
        n_checks++; if (rty_a !== 1'b0) begin n_fail++; $display("FAIL reset_rty: got %b want 0", rty_a); end
    endtask

    task automatic test_classic();
        logic [31:0] rd; int lat; bit e, post;
        classic_xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat, e, post);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL classic_wr_latency: got %0d want 2", lat); end
        n_checks++; if (e !== 1'b0 || post !== 1'b0) begin n_fail++; $display("FAIL classic_wr_resp: got err=%b post=%b want 0/0", e, post); end
        n_checks++; if (wrc_a !== 32'd1) begin n_fail++; $display("FAIL classic_wr_count: got %0d want 1", wrc_a); end
        exp_dat_q.push_back(32'hDEADBEEF);
        classic_xfer(0, 0, 32'h10, 32'h0, 4'hF, rd, lat, e, post);
        n_checks++; if (rd !== exp_dat_q.pop_front()) begin n_fail++; $display("FAIL classic_rd_data: got %h want deadbeef", rd); end
        n_checks++; if (lat < 2 || lat > 6) begin n_fail++; $display("FAIL classic_rd_latency: got %0d want 2..6", lat); end
        n_checks++; if (rdc_a !== 32'd1) begin n_fail++; $display("FAIL classic_rd_count: got %0d want 1", rdc_a); end
    endtask

    task automatic test_sel_read();
        logic [31:0] rd; int lat; bit e, post;
        exp_dat_q.push_back(32'h00AD00EF);
        classic_xfer(0, 0, 32'h10, 32'h0, 4'b0101, rd, lat, e, post);
        n_checks++; if (rd !== exp_dat_q.pop_front()) begin n_fail++; $display("FAIL sel_rd_data: got %h want 00ad00ef", rd); end
        n_checks++; if (rdc_a !== 32'd2) begin n_fail++; $display("FAIL sel_rd_count: got %0d want 2", rdc_a); end
    endtask

    task automatic test_wrap_burst();
        logic [31:0] addrs [4];
        logic [31:0] rd; int lat; bit e, post;
        int acks = 0;
        addrs[0] = 32'h0C; addrs[1] = 32'h00; addrs[2] = 32'h04; addrs[3] = 32'h08;
        tgt = 0; we = 1; sel = 4'hF; bte = 2'b01; cyc = 1; stb = 1;
        for (int i = 0; i < 4; i++) begin
            int waited = 0;
            adr = addrs[i]; dat = 32'hA5A50000 + i; cti = (i == 3) ? 3'b111 : 3'b010;
            forever begin
                @(negedge clk); waited++;
                if (ack_m) begin acks++; break; end
                if (err_m || waited >= 40) break;
            end
            @(posedge clk);
            #1;
        end
        cyc = 0; stb = 0; we = 0; cti = 0; bte = 0;
        n_checks++; if (acks !== 4) begin n_fail++; $display("FAIL wrap_acks: got %0d want 4", acks); end
        @(negedge clk);
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL wrap_idle: got busy=%b want 0", busy_a); end
        n_checks++; if (wrc_a !== 32'd5) begin n_fail++; $display("FAIL wrap_wr_count: got %0d want 5", wrc_a); end
        for (int i = 0; i < 4; i++) exp_dat_q.push_back(32'hA5A50000 + i);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ex;
            classic_xfer(0, 0, addrs[i], 32'h0, 4'hF, rd, lat, e, post);
            ex = exp_dat_q.pop_front();
            n_checks++; if (rd !== ex) begin n_fail++; $display("FAIL wrap_readback: adr %h got %h want %h", addrs[i], rd, ex); end
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; int lat; bit e, post;
        logic [31:0] rc0, wc0;
        rc0 = rdc_a; wc0 = wrc_a;
        classic_xfer(0, 0, 32'h8000, 32'h0, 4'hF, rd, lat, e, post);
        n_checks++; if (e !== 1'b1 || lat < 2) begin n_fail++; $display("FAIL oob_err: got err=%b lat=%0d want err=1", e, lat); end
        n_checks++; if (post !== 1'b0) begin n_fail++; $display("FAIL oob_err_width: got post=%b want 0", post); end
        n_checks++; if (rd !== 32'hA5A50003) begin n_fail++; $display("FAIL oob_dat_hold: got %h want a5a50003", rd); end
        n_checks++; if (rdc_a !== rc0 || wrc_a !== wc0) begin n_fail++; $display("FAIL oob_counts: got %0d/%0d want %0d/%0d", rdc_a, wrc_a, rc0, wc0); end
    endtask

    task automatic test_fixed_latency();
        logic [31:0] rd; int lat; bit e, post;
        classic_xfer(1, 1, 32'h40, 32'hCAFEF00D, 4'hF, rd, lat, e, post);
        for (int i = 0; i < 8; i++) begin
            exp_dat_q.push_back(32'hCAFEF00D);
            exp_lat_q.push_back(4);
            classic_xfer(1, 0, 32'h40, 32'h0, 4'hF, rd, lat, e, post);
            begin
                logic [31:0] ed; int el;
                ed = exp_dat_q.pop_front(); el = exp_lat_q.pop_front();
                n_checks++; if (lat !== el) begin n_fail++; $display("FAIL fixed_latency[%0d]: got %0d want %0d", i, lat, el); end
                n_checks++; if (rd !== ed) begin n_fail++; $display("FAIL fixed_data[%0d]: got %h want %h", i, rd, ed); end
            end
        end
        n_checks++; if (rdc_b !== 32'd8) begin n_fail++; $display("FAIL fixed_rd_count: got %0d want 8", rdc_b); end
        tgt = 0;
    endtask

    task automatic test_lfsr_repeat();
        logic [31:0] rd; int lat; bit e, post;
        int first [8];
        for (int run = 0; run < 2; run++) begin
            logic [15:0] l;
            do_reset();
            l = 16'hACE1;
            for (int i = 0; i < 8; i++) begin
                int el;
                exp_lat_q.push_back(2 + int'(l % 16'd5));
                l = lfsr_step(l);
                classic_xfer(0, 0, 32'h10, 32'h0, 4'hF, rd, lat, e, post);
                el = exp_lat_q.pop_front();
                n_checks++; if (lat !== el || lat < 2 || lat > 6) begin n_fail++; $display("FAIL rand_latency[%0d][%0d]: got %0d want %0d", run, i, lat, el); end
                if (run == 0) first[i] = lat;
                else begin
                    n_checks++; if (lat !== first[i]) begin n_fail++; $display("FAIL rand_repeat[%0d]: got %0d want %0d", i, lat, first[i]); end
                end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] rd; int lat; bit e, post;
        bit saw_ack = 0;
        classic_xfer(0, 1, 32'h20, 32'h11223344, 4'hF, rd, lat, e, post);
        tgt = 0; we = 1; adr = 32'h20; dat = 32'hBADBAD00; sel = 4'hF; cti = 0; cyc = 1; stb = 1;
        @(posedge clk);
        #2;
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b want 1", busy_a); end
        rst = 1;
        #1;
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_async: got %b want 0", busy_a); end
        n_checks++; if (rdc_a !== 32'h0 || wrc_a !== 32'h0) begin n_fail++; $display("FAIL rstmid_counts: got %0d/%0d want 0/0", rdc_a, wrc_a); end
        repeat (3) begin
            @(negedge clk);
            if (ack_a) saw_ack = 1;
        end
        cyc = 0; stb = 0; we = 0;
        @(posedge clk);
        #1 rst = 0;
        n_checks++; if (saw_ack !== 1'b0) begin n_fail++; $display("FAIL rstmid_ack: got %b want 0", saw_ack); end
        exp_dat_q.push_back(32'h11223344);
        classic_xfer(0, 0, 32'h20, 32'h0, 4'hF, rd, lat, e, post);
        begin
            logic [31:0] ed;
            ed = exp_dat_q.pop_front();
            n_checks++; if (rd !== ed) begin n_fail++; $display("FAIL rstmid_mem: got %h want %h", rd, ed); end
        end
    endtask

    initial begin
        adr = 0; dat = 0; sel = 0; we = 0; bte = 0; cti = 0; cyc = 0; stb = 0; tgt = 0; rst = 0;
        test_reset();
        test_classic();
        test_sel_read();
        test_wrap_burst();
        test_out_of_range();
        test_fixed_latency();
        test_lfsr_repeat();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
